// File: rtl/accum_drain_ctrl.sv
// ============================================================================
// accum_drain_ctrl : drains accumulator rows, rescales psums, writes out banks.
// Optional ReLU output path enabled by defining ACCUM_DRAIN_RELU_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module accum_drain_ctrl #(
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int ACCUM_SIZE = 1024,
  localparam int ACCUM_ROW = ACCUM_SIZE / SYS_COL,
  localparam int ROW_AW    = $clog2(ACCUM_ROW)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   num_row,
  input  logic [ROW_AW-1:0]       accum_base_addr,
  input  logic [ADDR_WIDTH-1:0]   out_base_addr,
  input  logic [4:0]              shift,
  output logic [SYS_COL-1:0]      accum_rd_en,
  output logic [ROW_AW-1:0]       accum_rd_addr [SYS_COL],
  input  logic [2*DATA_WIDTH-1:0] accum_rd_data [SYS_COL],
  output logic [SYS_COL-1:0]      out_wr_en,
  output logic [ADDR_WIDTH-1:0]   out_wr_addr [SYS_COL],
  output logic [DATA_WIDTH-1:0]   out_wr_data [SYS_COL],
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   k_q, k_d;
  logic                    flush_q, flush_d;

  logic [DATA_WIDTH-1:0]   num_row_q;
  logic [ROW_AW-1:0]       abase_q;
  logic [ADDR_WIDTH-1:0]   obase_q;
  logic [4:0]              shift_q;

  logic                    rd_valid_q;
  logic [ADDR_WIDTH-1:0]   koff_q;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q [SYS_COL];

  logic                    reading;
  logic                    accept;

  assign reading = (state_q == READ);
  assign accept  = (state_q == IDLE) && en;

  // Arithmetic shift (floor), saturate to the signed output range, optional ReLU.
  function automatic logic [DATA_WIDTH-1:0] rescale(
    input logic [2*DATA_WIDTH-1:0] psum,
    input logic [4:0]              sh
  );
    logic signed [2*DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0]          sat;
    r = $signed(psum) >>> sh;
    if ((&r[2*DATA_WIDTH-1:DATA_WIDTH-1]) || !(|r[2*DATA_WIDTH-1:DATA_WIDTH-1])) begin
      sat = r[DATA_WIDTH-1:0];
    end else if (r[2*DATA_WIDTH-1]) begin
      sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`ifdef ACCUM_DRAIN_RELU_EN
    if (sat[DATA_WIDTH-1]) begin
      sat = '0;
    end
`else
`endif
    return sat;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q     <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    flush_d = flush_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          k_d     = '0;
          flush_d = 1'b0;
          state_d = (num_row == '0) ? DONE : READ;
        end
      end
      READ: begin
        k_d = k_q + DATA_WIDTH'(1);
        if (k_q == num_row_q - DATA_WIDTH'(1)) begin
          state_d = FLUSH;
          flush_d = 1'b0;
        end
      end
      FLUSH: begin
        // Two cycles: one for the read-data stage, one for the rescale stage.
        flush_d = 1'b1;
        if (flush_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_row_q <= '0;
      abase_q   <= '0;
      obase_q   <= '0;
      shift_q   <= '0;
    end else if (accept) begin
      num_row_q <= num_row;
      abase_q   <= accum_base_addr;
      obase_q   <= out_base_addr;
      shift_q   <= shift;
    end
  end

  // Row offset travels with the read so the write address lines up with the data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid_q <= 1'b0;
      koff_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      rd_valid_q <= reading;
      if (reading) begin
        koff_q <= k_q[ADDR_WIDTH-1:0];
      end
      wr_en_q <= rd_valid_q;
      if (rd_valid_q) begin
        wr_addr_q <= obase_q + koff_q;
      end
    end
  end

  assign accum_rd_en = {SYS_COL{reading}};
  assign out_wr_en   = {SYS_COL{wr_en_q}};
  assign busy        = (state_q == READ) || (state_q == FLUSH);
  assign done        = (state_q == DONE);

  generate
    for (genvar c = 0; c < SYS_COL; c++) begin : g_col
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wr_data_q[c] <= '0;
        end else if (rd_valid_q) begin
          wr_data_q[c] <= rescale(accum_rd_data[c], shift_q);
        end
      end

      assign accum_rd_addr[c] = reading ? (abase_q + k_q[ROW_AW-1:0]) : '0;
      assign out_wr_addr[c]   = wr_addr_q;
      assign out_wr_data[c]   = wr_data_q[c];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_accum_drain_ctrl.sv
// Directed bench for accum_drain_ctrl: behavioural accumulator read port plus
// cycle-by-cycle checks of read/write/busy/done timing and rescaled data.
`default_nettype none

module tb_accum_drain_ctrl;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [15:0] num_row;
  logic [7:0]  accum_base_addr;
  logic [7:0]  out_base_addr;
  logic [4:0]  shift;
  logic [3:0]  accum_rd_en;
  logic [7:0]  accum_rd_addr [4];
  logic [31:0] accum_rd_data [4];
  logic [3:0]  out_wr_en;
  logic [7:0]  out_wr_addr [4];
  logic [15:0] out_wr_data [4];
  logic        busy;
  logic        done;

  logic [31:0] mem [256][4];
  logic [15:0] exp_data [8][4];

  int total;
  int passed;

  accum_drain_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .en              (en),
    .num_row         (num_row),
    .accum_base_addr (accum_base_addr),
    .out_base_addr   (out_base_addr),
    .shift           (shift),
    .accum_rd_en     (accum_rd_en),
    .accum_rd_addr   (accum_rd_addr),
    .accum_rd_data   (accum_rd_data),
    .out_wr_en       (out_wr_en),
    .out_wr_addr     (out_wr_addr),
    .out_wr_data     (out_wr_data),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator read port: one-cycle read latency.
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (accum_rd_en[c]) accum_rd_data[c] <= mem[accum_rd_addr[c]][c];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " rd_en"}, 32'(accum_rd_en), 32'h0);
    chk({tag, " wr_en"}, 32'(out_wr_en), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " done"}, 32'(done), 32'h0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s rd_addr[%0d]", tag, c), 32'(accum_rd_addr[c]), 32'h0);
      chk($sformatf("%s wr_addr[%0d]", tag, c), 32'(out_wr_addr[c]), 32'h0);
      chk($sformatf("%s wr_data[%0d]", tag, c), 32'(out_wr_data[c]), 32'h0);
    end
  endtask

  // Starts a drain from the current negedge (cycle 0) and checks cycles 1..n+4.
  // en2 > 0 raises en again in that cycle with a different num_row.
  task automatic drain(input string tag, input int n, input logic [7:0] ab,
                       input logic [7:0] ob, input logic [4:0] sh, input int en2);
    logic [7:0] ea;
    logic [7:0] eo;
    int         done_cyc;
    num_row = 16'(n);
    accum_base_addr = ab;
    out_base_addr = ob;
    shift = sh;
    en = 1'b1;
    done_cyc = (n == 0) ? 1 : n + 3;
    for (int t = 1; t <= n + 4; t++) begin
      @(posedge clk);
      @(negedge clk);
      en = (t == en2);
      if (t == en2) num_row = 16'd9;
      ea = ab + 8'(t - 1);
      eo = ob + 8'(t - 3);
      chk($sformatf("%s rd_en t=%0d", tag, t), 32'(accum_rd_en),
          (t >= 1 && t <= n) ? 32'hF : 32'h0);
      if (t >= 1 && t <= n) begin
        for (int c = 0; c < 4; c++)
          chk($sformatf("%s rd_addr[%0d] t=%0d", tag, c, t), 32'(accum_rd_addr[c]), 32'(ea));
      end
      chk($sformatf("%s wr_en t=%0d", tag, t), 32'(out_wr_en),
          (t >= 3 && t <= n + 2) ? 32'hF : 32'h0);
      if (t >= 3 && t <= n + 2) begin
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("%s wr_addr[%0d] t=%0d", tag, c, t), 32'(out_wr_addr[c]), 32'(eo));
          chk($sformatf("%s wr_data[%0d] t=%0d", tag, c, t), 32'(out_wr_data[c]),
              32'(exp_data[t-3][c]));
        end
      end
      chk($sformatf("%s busy t=%0d", tag, t), 32'(busy),
          (n > 0 && t <= n + 2) ? 32'h1 : 32'h0);
      chk($sformatf("%s done t=%0d", tag, t), 32'(done), (t == done_cyc) ? 32'h1 : 32'h0);
    end
    en = 1'b0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rstn = 1'b0;
    en = 1'b0;
    num_row = '0;
    accum_base_addr = '0;
    out_base_addr = '0;
    shift = '0;
    for (int r = 0; r < 256; r++)
      for (int c = 0; c < 4; c++) mem[r][c] = '0;
    for (int c = 0; c < 4; c++) accum_rd_data[c] = '0;

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post-reset");

    // Basic drain: row k col c holds 10k+c.
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        mem[k][c] = 32'(10 * k + c);
        exp_data[k][c] = 16'(10 * k + c);
      end
    drain("basic", 4, 8'd0, 8'd0, 5'd0, 0);

    // Saturation, shift 0.
    mem[20][0] = 32'h0003_0000;
    mem[20][1] = -32'sd70000;
    mem[20][2] = 32'd5;
    mem[20][3] = -32'sd3;
    exp_data[0][0] = 16'h7FFF;
`ifdef ACCUM_DRAIN_RELU_EN
    exp_data[0][1] = 16'h0000;
    exp_data[0][3] = 16'h0000;
`else
    exp_data[0][1] = 16'h8000;
    exp_data[0][3] = 16'hFFFD;
`endif
    exp_data[0][2] = 16'h0005;
    drain("sat", 1, 8'd20, 8'd40, 5'd0, 0);

    // Shift 4: 0x100 -> 0x10, -17 -> -2, large positive/negative saturate.
    mem[30][0] = 32'h0000_0100;
    mem[30][1] = -32'sd17;
    mem[30][2] = 32'h7FFF_FFFF;
    mem[30][3] = 32'h8000_0000;
    exp_data[0][0] = 16'h0010;
    exp_data[0][2] = 16'h7FFF;
`ifdef ACCUM_DRAIN_RELU_EN
    exp_data[0][1] = 16'h0000;
    exp_data[0][3] = 16'h0000;
`else
    exp_data[0][1] = 16'hFFFE;
    exp_data[0][3] = 16'h8000;
`endif
    drain("shift4", 1, 8'd30, 8'd7, 5'd4, 0);

    // Shift 2: -17 -> -5 (floor), 0x100 -> 0x40, 7 -> 1, -1 -> -1.
    mem[31][0] = -32'sd17;
    mem[31][1] = 32'h0000_0100;
    mem[31][2] = 32'd7;
    mem[31][3] = 32'hFFFF_FFFF;
    exp_data[0][1] = 16'h0040;
    exp_data[0][2] = 16'h0001;
`ifdef ACCUM_DRAIN_RELU_EN
    exp_data[0][0] = 16'h0000;
    exp_data[0][3] = 16'h0000;
`else
    exp_data[0][0] = 16'hFFFB;
    exp_data[0][3] = 16'hFFFF;
`endif
    drain("shift2", 1, 8'd31, 8'd8, 5'd2, 0);

    // Wrap: reads rows 254,255,0 and writes addresses 255,0,1.
    for (int c = 0; c < 4; c++) begin
      mem[254][c] = 32'(100 + c);
      mem[255][c] = 32'(200 + c);
      mem[0][c]   = 32'(300 + c);
      exp_data[0][c] = 16'(100 + c);
      exp_data[1][c] = 16'(200 + c);
      exp_data[2][c] = 16'(300 + c);
    end
    drain("wrap", 3, 8'd254, 8'd255, 5'd0, 0);

    // Zero rows: done in cycle 1, nothing else.
    drain("zero", 0, 8'd5, 8'd5, 5'd0, 0);

    // Second en during READ must not restart or relatch num_row.
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        mem[k][c] = 32'(10 * k + c);
        exp_data[k][c] = 16'(10 * k + c);
      end
    drain("en2", 4, 8'd0, 8'd0, 5'd0, 2);

    // Reset in cycle 3 of a 4-row drain.
    num_row = 16'd4;
    accum_base_addr = 8'd0;
    out_base_addr = 8'd0;
    shift = 5'd0;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst-mid pre wr_en", 32'(out_wr_en), 32'hF);
    rstn = 1'b0;
    #1;
    chk_idle_outputs("rst-mid");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk($sformatf("rst-after rd_en t=%0d", t), 32'(accum_rd_en), 32'h0);
      chk($sformatf("rst-after wr_en t=%0d", t), 32'(out_wr_en), 32'h0);
      chk($sformatf("rst-after done t=%0d", t), 32'(done), 32'h0);
      chk($sformatf("rst-after busy t=%0d", t), 32'(busy), 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
